cnn_residual_add: RTL and testbench
===================================

# cnn_residual_add

Parametrised residual-join stage for ResNet basic blocks: adds the identity (skip) stream to the conv-path (main) stream element by element, applies optional saturation and post-add ReLU, and tracks frame boundaries. It sits at the tail of every basic block. Skip-path pixels are buffered in an internal FIFO so that the identity input may run ahead of the conv pipeline by up to FIFO_DEPTH pixels. Error flags report misalignment.

## Interface
- DATA_WIDTH, 32, pixel width; signed two's-complement fixed point.
- IMAGE_WIDTH, 128, feature-map width.
- IMAGE_HEIGHT, 128, feature-map height.
- CHANNEL_NUM, 512, channels per frame; frame = IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM pixels.
- FIFO_DEPTH, 1024, skip-FIFO entries; power of two, ≥2.
- RELU_EN, 1, 1 = clamp negative sums to 0.
- SATURATE, 1, 1 = clamp overflow to max/min signed; 0 = wrap (modulo 2^DATA_WIDTH).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in_skip  in  1  skip pixel strobe.
- in_skip  in  DATA_WIDTH  skip pixel.
- valid_in_main  in  1  conv-path pixel strobe.
- in_main  in  DATA_WIDTH  conv-path pixel.
- pxl_out  out  DATA_WIDTH  result pixel.
- valid_out  out  1  result strobe.
- frame_done  out  1  one-cycle pulse, coincident with the last pixel of a frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current skip-FIFO occupancy.
- overflow  out  1  sticky: skip pixel dropped because the FIFO was full.
- underflow  out  1  sticky: main pixel arrived with no skip pixel available.

## Operation
- Valid-only streams; no backpressure. Each valid strobe carries exactly one pixel.
- Skip FIFO: synchronous, circular buffer; read/write pointers carry one extra wrap bit, so full = MSBs differ and LSBs equal.
- Pairing: each main pixel pops one skip operand, in order.
- Operand source on valid_in_main:
  - FIFO not empty: operand = FIFO head; pop. A skip pixel in the same cycle is pushed.
  - FIFO empty and valid_in_skip in the same cycle: bypass; operand = in_skip, no push, level stays 0.
  - FIFO empty and no skip: operand = 0; underflow set.
- Push rules:
  - valid_in_skip with FIFO full and no pop this cycle: pixel dropped; overflow set.
  - Full plus simultaneous pop: push accepted; level unchanged.
- Stage 1: sum = sign-extended (DATA_WIDTH+1)-bit add of in_main and the operand, registered.
- Stage 2: result registered to pxl_out.
  - SATURATE=1: sum > 2^(DATA_WIDTH-1)-1 → max; sum < -2^(DATA_WIDTH-1) → min.
  - SATURATE=0: low DATA_WIDTH bits.
  - RELU_EN=1: negative result → 0, applied after saturation.
- Pixel counter:
  - Counts valid_out pixels from 0 to frame−1, then wraps to 0.
  - frame_done is asserted with valid_out on count frame−1.
- Flags are sticky until reset.

## Timing
- Latency: valid_in_main at cycle N → valid_out at cycle N+2. Throughput 1 pixel/clk; back-to-back strobes are supported.
- fifo_level updates the cycle after a push or pop.
- Reset asserted (low), including mid-frame: immediately pxl_out=0, valid_out=0, frame_done=0, fifo_level=0, overflow=0, underflow=0. Pointers, counter and pipeline are cleared; in-flight pixels are discarded.
- First clock edge after reset deassertion: inputs are sampled normally.
- valid_out is never asserted without a corresponding valid_in_main two cycles earlier.

## Test plan
- Bench parameters: DATA_WIDTH=16, IMAGE 2x2, CHANNEL_NUM=2 (frame=8), FIFO_DEPTH=4.
- Aligned streams: skip=100 and main=−30 every cycle for 8 cycles → eight outputs of 70, two cycles later; frame_done only with the 8th; fifo_level stays 0; no flags.
- Skip leads by 3: skip 1,2,3 then both streams with main=10 → outputs 11,12,13…; fifo_level=3 steady; a 9th output restarts the count and the 16th pulses frame_done.
- Saturation/ReLU: main=32000 + skip=1000 → 32767. main=−32000 + skip=−1000 → 0 (RELU_EN=1), or −32768 with RELU_EN=0.
- SATURATE=0, RELU_EN=0: 32767+1 → −32768.
- Overflow: 5 skip pixels with no main → 5th dropped, overflow=1, level=4. Then 4 main pixels pop the first 4 skip values; the 5th main → underflow=1, output = main.
- Reset mid-frame after 5 outputs with level=2: all outputs 0 and level 0. A new 8-pixel frame then pulses frame_done on its 8th output.

Source files
------------

// File: rtl/cnn_residual_add.sv
// Residual join for ResNet basic blocks: skip stream buffered in a FIFO, added to the conv stream,
// then saturated / ReLU'd over a two-stage pipeline, with frame-boundary tracking and sticky error flags.
module cnn_residual_add #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int CHANNEL_NUM  = 512,
    parameter int FIFO_DEPTH   = 1024,
    parameter int RELU_EN      = 1,
    parameter int SATURATE     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in_skip,
    input  logic [DATA_WIDTH-1:0]         in_skip,
    input  logic                          valid_in_main,
    input  logic [DATA_WIDTH-1:0]         in_main,
    output logic [DATA_WIDTH-1:0]         pxl_out,
    output logic                          valid_out,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    // Streams are valid-only: a pixel is transferred on every cycle its valid is high,
    // there is no ready/backpressure, so excess skip pixels are dropped and missing ones read as 0.

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FRAME = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM;
    localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  bypass;
    logic                  starve;
    logic                  push;
    logic                  drop;
    logic [DATA_WIDTH-1:0] operand;

    logic [DATA_WIDTH:0]   sum_q;
    logic                  sum_valid;
    logic [DATA_WIDTH-1:0] result;
    logic [CW-1:0]         pxl_cnt;
    logic                  last_pxl;

    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop    = valid_in_main && !empty;
        bypass = valid_in_main && empty && valid_in_skip;
        starve = valid_in_main && empty && !valid_in_skip;
        // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
        push   = valid_in_skip && !bypass && (!full || pop);
        drop   = valid_in_skip && full && !pop;
        operand = '0;
        if (pop) begin
            operand = mem[rd_ptr[AW-1:0]];
        end else if (bypass) begin
            operand = in_skip;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_skip;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
            if (starve) underflow <= 1'b1;
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q     <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= valid_in_main;
            if (valid_in_main) begin
                sum_q <= {in_main[DATA_WIDTH-1], in_main} + {operand[DATA_WIDTH-1], operand};
            end
        end
    end

    // The two top bits of the extended sum disagree exactly when the result left the signed range.
    always_comb begin
        result = sum_q[DATA_WIDTH-1:0];
        if (SATURATE != 0 && (sum_q[DATA_WIDTH] != sum_q[DATA_WIDTH-1])) begin
            result = sum_q[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        end
        if (RELU_EN != 0 && result[DATA_WIDTH-1]) begin
            result = '0;
        end
    end

    assign last_pxl = (pxl_cnt == CW'(FRAME - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            pxl_cnt    <= '0;
        end else begin
            valid_out  <= sum_valid;
            frame_done <= sum_valid && last_pxl;
            if (sum_valid) begin
                pxl_out <= result;
                pxl_cnt <= last_pxl ? '0 : pxl_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cnn_residual_add.sv
// Scoreboard bench for cnn_residual_add: three configurations (sat+relu, sat only, wrap) share
// one stimulus stream and are checked against a queue-based model of the pairing and arithmetic rules.
module tb_cnn_residual_add;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in_skip = 1'b0;
    logic [DW-1:0] in_skip = '0;
    logic          valid_in_main = 1'b0;
    logic [DW-1:0] in_main = '0;

    logic [DW-1:0] pxl_a, pxl_b, pxl_c;
    logic          valid_a, valid_b, valid_c;
    logic          fd_a, fd_b, fd_c;
    logic [LW-1:0] level_a, level_b, level_c;
    logic          ovf_a, ovf_b, ovf_c;
    logic          unf_a, unf_b, unf_c;

    always #5 clk = ~clk;

    cnn_residual_add #(.DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM(2),
        .FIFO_DEPTH(DEPTH), .RELU_EN(1), .SATURATE(1)) dut_a (
        .clk(clk), .reset(reset), .valid_in_skip(valid_in_skip), .in_skip(in_skip),
        .valid_in_main(valid_in_main), .in_main(in_main), .pxl_out(pxl_a), .valid_out(valid_a),
        .frame_done(fd_a), .fifo_level(level_a), .overflow(ovf_a), .underflow(unf_a));

    cnn_residual_add #(.DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM(2),
        .FIFO_DEPTH(DEPTH), .RELU_EN(0), .SATURATE(1)) dut_b (
        .clk(clk), .reset(reset), .valid_in_skip(valid_in_skip), .in_skip(in_skip),
        .valid_in_main(valid_in_main), .in_main(in_main), .pxl_out(pxl_b), .valid_out(valid_b),
        .frame_done(fd_b), .fifo_level(level_b), .overflow(ovf_b), .underflow(unf_b));

    cnn_residual_add #(.DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM(2),
        .FIFO_DEPTH(DEPTH), .RELU_EN(0), .SATURATE(0)) dut_c (
        .clk(clk), .reset(reset), .valid_in_skip(valid_in_skip), .in_skip(in_skip),
        .valid_in_main(valid_in_main), .in_main(in_main), .pxl_out(pxl_c), .valid_out(valid_c),
        .frame_done(fd_c), .fifo_level(level_c), .overflow(ovf_c), .underflow(unf_c));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model state: skip pixels waiting, expected results {frame_done, a, b, c} and their due cycle.
    int            skip_q[$];
    logic [48:0]   exp_q[$];
    int            due_q[$];
    int            out_cnt = 0;
    int            exp_level = 0;
    bit            exp_ovf = 1'b0;
    bit            exp_unf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_result(input int s, input bit sat, input bit relu);
        int r;
        if (sat) begin
            if (s > 32767) r = 32767;
            else if (s < -32768) r = -32768;
            else r = s;
        end else begin
            r = s % 65536;
            if (r < 0) r += 65536;
            if (r >= 32768) r -= 65536;
        end
        if (relu && r < 0) r = 0;
        return r[DW-1:0];
    endfunction

    task automatic cycle(input bit vs, input int s, input bit vm, input int m);
        bit used;
        int op;
        int sum;
        bit fd;
        @(negedge clk);
        valid_in_skip = vs;
        in_skip       = s[DW-1:0];
        valid_in_main = vm;
        in_main       = m[DW-1:0];
        used = 1'b0;
        op   = 0;
        if (vm) begin
            if (skip_q.size() > 0) op = skip_q.pop_front();
            else if (vs) begin
                op   = s;
                used = 1'b1;
            end else exp_unf = 1'b1;
            sum = m + op;
            fd  = (out_cnt == FRAME - 1);
            out_cnt = (out_cnt + 1) % FRAME;
            exp_q.push_back({fd, model_result(sum, 1, 1), model_result(sum, 1, 0), model_result(sum, 0, 0)});
            due_q.push_back(cyc + 2);
        end
        if (vs && !used) begin
            if (skip_q.size() < DEPTH) skip_q.push_back(s);
            else exp_ovf = 1'b1;
        end
        exp_level = skip_q.size();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic check_reset_state();
        check("reset_pxl_a", pxl_a, 0);
        check("reset_pxl_b", pxl_b, 0);
        check("reset_pxl_c", pxl_c, 0);
        check("reset_valid", {valid_a, valid_b, valid_c}, 0);
        check("reset_frame_done", {fd_a, fd_b, fd_c}, 0);
        check("reset_level", level_a, 0);
        check("reset_flags", {ovf_a, unf_a}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        valid_in_skip = 1'b0;
        valid_in_main = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_state();
        skip_q.delete();
        exp_q.delete();
        due_q.delete();
        out_cnt = 0;
        exp_level = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic drain();
        idle(3);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: every cycle either the head result is due and must appear, or no output may appear.
    always begin
        logic [48:0] e;
        int d;
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("level_a", level_a, exp_level);
            check("level_b", level_b, exp_level);
            check("level_c", level_c, exp_level);
            check("overflow", {ovf_a, ovf_b, ovf_c}, {3{exp_ovf}});
            check("underflow", {unf_a, unf_b, unf_c}, {3{exp_unf}});
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check("valid_out", {valid_a, valid_b, valid_c}, 3'b111);
                check("pxl_sat_relu", pxl_a, e[47:32]);
                check("pxl_sat", pxl_b, e[31:16]);
                check("pxl_wrap", pxl_c, e[15:0]);
                check("frame_done", {fd_a, fd_b, fd_c}, {3{e[48]}});
            end else begin
                check("valid_idle", {valid_a, valid_b, valid_c}, 0);
                check("frame_done_idle", {fd_a, fd_b, fd_c}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check_reset_state();
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // Aligned streams: bypass path, level stays 0.
        for (int i = 0; i < 8; i++) cycle(1, 100, 1, -30);
        drain();

        // Skip leads by 3, then 16 paired pixels across two frames.
        do_reset();
        for (int i = 1; i <= 3; i++) cycle(1, i, 0, 0);
        for (int i = 4; i <= 19; i++) cycle(1, i, 1, 10);
        drain();

        // Saturation, ReLU and wrap corners.
        do_reset();
        cycle(1, 1000, 1, 32000);
        cycle(1, -1000, 1, -32000);
        cycle(1, 1, 1, 32767);
        cycle(1, -32768, 1, -32768);
        cycle(1, 0, 1, -5);
        drain();

        // Overflow then underflow.
        do_reset();
        for (int i = 11; i <= 15; i++) cycle(1, i, 0, 0);
        for (int i = 1; i <= 5; i++) cycle(0, 0, 1, i);
        drain();

        // Full FIFO with simultaneous pop and push.
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1, i * 7, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 50 + i, 1, -i);
        drain();

        // Random traffic: skip-heavy phase then main-heavy phase.
        do_reset();
        for (int i = 0; i < 240; i++) begin
            bit vs;
            bit vm;
            vs = ($urandom_range(0, 99) < ((i < 120) ? 80 : 50));
            vm = ($urandom_range(0, 99) < ((i < 120) ? 50 : 80));
            cycle(vs, int'($urandom_range(0, 65535)) - 32768, vm, int'($urandom_range(0, 65535)) - 32768);
        end
        drain();

        // Mid-frame reset with pixels buffered and in flight, then a clean frame.
        do_reset();
        cycle(1, 1, 0, 0);
        cycle(1, 2, 0, 0);
        for (int i = 3; i <= 7; i++) cycle(1, i, 1, 10);
        idle(2);
        cycle(1, 50, 1, 10);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, i, 1, 20);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
